// File: rtl/data_ram_responder_if.sv
// Request/response bundle between the execute-stage requester and the data RAM.
// Handshake: data_ram_en qualifies addr/w_data/w_en_4bit for that one cycle; there is no ready, a READY request always completes and r_data follows one edge later.
interface data_ram_responder_if;
  logic        data_ram_en;
  logic [31:0] data_ram_addr;
  logic [31:0] data_ram_w_data;
  logic [3:0]  data_ram_w_en_4bit;
  logic [31:0] data_ram_r_data;

  modport master (
    output data_ram_en, data_ram_addr, data_ram_w_data, data_ram_w_en_4bit,
    input  data_ram_r_data
  );

  modport slave (
    input  data_ram_en, data_ram_addr, data_ram_w_data, data_ram_w_en_4bit,
    output data_ram_r_data
  );
endinterface

// File: rtl/data_ram_responder.sv
// Byte-writable synchronous data RAM with post-reset self-clear, registered
// read-first output and a sticky out-of-range access flag.
module data_ram_responder #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  data_ram_responder_if.slave   bus,
  input  logic                  err_clr,
  output logic                  init_done,
  output logic                  addr_err,
  output logic                  dbg_state
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int              DEPTH       = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_WORD   = (ADDR_W + 1)'(DEPTH - 1);
  localparam state_t          RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  logic [31:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]     r_data_q, r_data_d;
  logic            addr_err_q, addr_err_d;
  logic            init_done_q, init_done_d;

  logic [ADDR_W-1:0] word_idx;
  logic              out_of_range;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [31:0]       mem_wdata;

  // Byte-offset bits carry no meaning for a word memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.data_ram_addr[1:0];

  assign word_idx     = bus.data_ram_addr[ADDR_W+1:2];
  assign out_of_range = |bus.data_ram_addr[31:ADDR_W+2];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      r_data_q    <= '0;
      addr_err_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      r_data_q    <= r_data_d;
      addr_err_q  <= addr_err_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_WORD) state_d = ST_READY;
    end
  end

  // Output / datapath logic; the set of addr_err outranks err_clr.
  always_comb begin
    mem_we      = 4'h0;
    mem_widx    = word_idx;
    mem_wdata   = bus.data_ram_w_data;
    r_data_d    = r_data_q;
    addr_err_d  = addr_err_q & ~err_clr;
    init_done_d = (state_d == ST_READY);
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 4'hF;
        mem_widx  = clr_cnt_q[ADDR_W-1:0];
        mem_wdata = '0;
      end
      ST_READY: begin
        if (bus.data_ram_en) begin
          if (out_of_range) begin
            r_data_d   = '0;
            addr_err_d = 1'b1;
          end else begin
            r_data_d = mem[word_idx];
            mem_we   = bus.data_ram_w_en_4bit;
          end
        end
      end
      default: ;
    endcase
    // The array itself is not reset, so keep it untouched while reset is held.
    if (reset) mem_we = 4'h0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  assign bus.data_ram_r_data = r_data_q;
  assign init_done           = init_done_q;
  assign addr_err            = addr_err_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder (ADDR_W=10, CLEAR_ON_RESET=1).
module tb_data_ram_responder;

  logic clk;
  logic reset;
  logic err_clr;
  logic init_done;
  logic addr_err;
  logic dbg_state;

  int n_vec = 0;
  int n_err = 0;

  data_ram_responder_if bus ();

  data_ram_responder #(.ADDR_W(10), .CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_clr   (err_clr),
    .init_done (init_done),
    .addr_err  (addr_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    bus.data_ram_en        = 1'b0;
    bus.data_ram_addr      = 32'h0;
    bus.data_ram_w_data    = 32'h0;
    bus.data_ram_w_en_4bit = 4'h0;
    err_clr                = 1'b0;
  endtask

  task automatic drive(input logic en, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] we, input logic clr);
    bus.data_ram_en        = en;
    bus.data_ram_addr      = addr;
    bus.data_ram_w_data    = wd;
    bus.data_ram_w_en_4bit = we;
    err_clr                = clr;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after reset release until init_done, bounded.
  task automatic wait_init(output int cyc, output int drop_bad);
    cyc      = 0;
    drop_bad = 0;
    while (init_done !== 1'b1 && cyc < 1100) begin
      bus.data_ram_en        = 1'b1;
      bus.data_ram_addr      = cyc[0] ? 32'h0000_2000 : 32'h0000_0014;
      bus.data_ram_w_data    = 32'hFFFF_FFFF;
      bus.data_ram_w_en_4bit = 4'hF;
      @(posedge clk);
      #1;
      cyc++;
      if (init_done !== 1'b1 && (bus.data_ram_r_data !== 32'h0 || addr_err !== 1'b0))
        drop_bad++;
    end
    idle();
  endtask

  task automatic test_reset();
    int cyc, drop_bad;
    idle();
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0 || init_done !== 1'b0 || addr_err !== 1'b0 || dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: r_data=%h init_done=%b addr_err=%b state=%b, required 0/0/0/0",
               bus.data_ram_r_data, init_done, addr_err, dbg_state);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init(cyc, drop_bad);
    n_vec++;
    if (cyc !== 1024) begin
      n_err++;
      $display("FAIL clear_length: init_done after %0d cycles, required 1024", cyc);
    end
    n_vec++;
    if (drop_bad !== 0) begin
      n_err++;
      $display("FAIL clear_drop: %0d cycles with nonzero r_data/addr_err, required 0", drop_bad);
    end
    n_vec++;
    if (dbg_state !== 1'b1) begin
      n_err++;
      $display("FAIL ready_state: state=%b, required 1", dbg_state);
    end
    drive(1'b1, 32'h0000_0FFC, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0) begin
      n_err++;
      $display("FAIL read_last_word: got %h, required 00000000", bus.data_ram_r_data);
    end
    drive(1'b1, 32'h0000_0014, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0 || addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL clear_write_dropped: r_data=%h addr_err=%b, required 00000000/0",
               bus.data_ram_r_data, addr_err);
    end
  endtask

  task automatic test_byte_write();
    drive(1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 1'b0);
    drive(1'b1, 32'h0000_0011, 32'h0000_AA00, 4'b0010, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h1122_3344) begin
      n_err++;
      $display("FAIL byte_write_readfirst: got %h, required 11223344", bus.data_ram_r_data);
    end
    drive(1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h1122_AA44) begin
      n_err++;
      $display("FAIL byte_write_merge: got %h, required 1122aa44", bus.data_ram_r_data);
    end
  endtask

  task automatic test_read_first();
    drive(1'b1, 32'h0000_0020, 32'h0000_0005, 4'hF, 1'b0);
    drive(1'b1, 32'h0000_0020, 32'h0000_0009, 4'hF, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0000_0005) begin
      n_err++;
      $display("FAIL read_first_old: got %h, required 00000005", bus.data_ram_r_data);
    end
    drive(1'b1, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0000_0009) begin
      n_err++;
      $display("FAIL read_first_new: got %h, required 00000009", bus.data_ram_r_data);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 1'b0);
    drive(1'b1, 32'h0000_0000, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0 || addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL oor_access: r_data=%h addr_err=%b, required 00000000/1",
               bus.data_ram_r_data, addr_err);
    end
    drive(1'b1, 32'h0000_0000, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h1234_5678 || addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL oor_no_write_sticky: r_data=%h addr_err=%b, required 12345678/1",
               bus.data_ram_r_data, addr_err);
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    n_vec++;
    if (addr_err !== 1'b0 || bus.data_ram_r_data !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL err_clr: addr_err=%b r_data=%h, required 0/12345678", addr_err, bus.data_ram_r_data);
    end
    drive(1'b1, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1);
    n_vec++;
    if (addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL set_beats_clear: addr_err=%b, required 1", addr_err);
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    n_vec++;
    if (addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clr_again: addr_err=%b, required 0", addr_err);
    end
    idle();
  endtask

  task automatic test_hold();
    drive(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1'b0);
    drive(1'b1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL hold_read: got %h, required deadbeef", bus.data_ram_r_data);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i == 2) ? 32'h0000_0040 : 32'h0000_0044, 32'h5555_5555, 4'hF, 1'b0);
      n_vec++;
      if (bus.data_ram_r_data !== 32'hDEAD_BEEF) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got %h, required deadbeef", i, bus.data_ram_r_data);
      end
    end
    drive(1'b1, 32'h0000_0044, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0) begin
      n_err++;
      $display("FAIL hold_no_write_44: got %h, required 00000000", bus.data_ram_r_data);
    end
    drive(1'b1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL hold_no_write_40: got %h, required deadbeef", bus.data_ram_r_data);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'hFFFF_0000, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    idle();
    n_vec++;
    if (bus.data_ram_r_data !== 32'hDEAD_BEEF || addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: r_data=%h addr_err=%b, required deadbeef/1", bus.data_ram_r_data, addr_err);
    end
    #3;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0 || addr_err !== 1'b0 || init_done !== 1'b0 || dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: r_data=%h addr_err=%b init_done=%b state=%b, required 0/0/0/0",
               bus.data_ram_r_data, addr_err, init_done, dbg_state);
    end
  endtask

  task automatic test_reset_mid_clear();
    int cyc, drop_bad;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    n_vec++;
    if (init_done !== 1'b0 || dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL mid_clear_state: init_done=%b state=%b, required 0/0", init_done, dbg_state);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (init_done !== 1'b0 || bus.data_ram_r_data !== 32'h0 || addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL mid_clear_reset: init_done=%b r_data=%h addr_err=%b, required 0/0/0",
               init_done, bus.data_ram_r_data, addr_err);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init(cyc, drop_bad);
    n_vec++;
    if (cyc !== 1024) begin
      n_err++;
      $display("FAIL reclear_length: init_done after %0d cycles, required 1024", cyc);
    end
    drive(1'b1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0) begin
      n_err++;
      $display("FAIL reclear_word40: got %h, required 00000000", bus.data_ram_r_data);
    end
    drive(1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (bus.data_ram_r_data !== 32'h0) begin
      n_err++;
      $display("FAIL reclear_word10: got %h, required 00000000", bus.data_ram_r_data);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_byte_write();
    test_read_first();
    test_out_of_range();
    test_hold();
    test_async_reset();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Word-organised, byte-writable synchronous data memory that sits at the far end of the data-RAM port driven by the execute stage.
- Accepts enable, address, write data and a 4-bit byte-write mask in one cycle. Returns read data registered on the next clock edge, so the memory stage sees it one cycle later.
- Performs a self-clear of the whole array after reset, and flags accesses outside the implemented range.

Parameters:
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words of 32 bits (default 1024 words = 4 KiB).
- CLEAR_ON_RESET, 1, 1 = zero the array after reset before accepting accesses; 0 = go straight to READY with contents undefined.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_ram_en  in  1  access request this cycle.
- data_ram_addr  in  32  byte address; bits [1:0] ignored; word index = addr[ADDR_W+1:2].
- data_ram_w_data  in  32  write data, already byte-lane positioned by the requester.
- data_ram_w_en_4bit  in  4  byte-write mask; bit i writes bits [8i+7:8i]; 4'b0000 = read.
- data_ram_r_data  out  32  registered read data.
- init_done  out  1  high once the array is usable (READY state).
- addr_err  out  1  sticky flag: an access was made outside the implemented range.
- err_clr  in  1  synchronous clear of addr_err.

Behaviour:
Reset (asynchronous, any cycle, including mid-clear or mid-access):
- data_ram_r_data=0, addr_err=0, init_done=0, clr_cnt=0.
- State = CLEAR if CLEAR_ON_RESET=1, else READY.
- Array contents are not reset asynchronously.

FSM CLEAR:
- Each clock writes 32'h0 to word clr_cnt, then clr_cnt++.
- The edge that writes word DEPTH-1 moves the FSM to READY. CLEAR therefore lasts exactly DEPTH cycles after reset deasserts.
- Requests during CLEAR are dropped: no write, data_ram_r_data held at 0, addr_err unaffected.

FSM READY:
- init_done=1. Stays in READY until reset.

Out-of-range access:
- Defined as addr[31:ADDR_W+2] != 0.
- Range check applies only when en=1 in READY.
- Write is suppressed, data_ram_r_data<=0 on the next edge, addr_err<=1.

Access in READY with en=1 and address in range:
- Each lane with w_en_4bit[i]=1 is updated at the edge; other lanes keep their value.
- data_ram_r_data<=mem[word] with read-first semantics: the pre-write value is returned even when the same cycle writes that word.
- Latency is 1 cycle. A write on cycle N is visible to a read issued on cycle N+1.

en=0:
- No write. data_ram_r_data holds its previous value (required by the stalled memory stage).
- w_en_4bit is ignored.

addr_err:
- err_clr=1 clears it at the edge.
- If err_clr and a new out-of-range access occur in the same cycle, the set wins and addr_err=1.

Arithmetic and timing:
- clr_cnt is ADDR_W+1 bits wide and does not wrap inside CLEAR.
- There is no back-pressure; every READY in-range request completes in one cycle.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ADDR_W=10 -> init_done low for exactly 1024 cycles after reset falls, then high. A read of 0x0000_0FFC returns 0x0000_0000 one cycle later.
- Write 0x1122_3344 to 0x10 with mask 4'hF, then on the next cycle write 0xAA at 0x11 with data 0x0000_AA00 and mask 4'b0010 -> read of 0x10 returns 0x1122_AA44.
- Same-cycle read/write of 0x20 (old value 0x5, new data 0x9, mask 4'hF) -> r_data=0x5 next cycle. A following read of 0x20 returns 0x9.
- Read of 0x0000_1000 (out of range) -> r_data=0, addr_err=1, word 0 unchanged. err_clr pulse -> addr_err=0. err_clr coinciding with another out-of-range access -> addr_err stays 1.
- Read of 0x40 returning 0xDEAD_BEEF, then 3 cycles with en=0 and w_en_4bit=4'hF -> r_data holds 0xDEAD_BEEF and mem[0x40] is unchanged.
- Assert reset at clear cycle 500 -> outputs zero immediately, without waiting for a clock. CLEAR restarts at word 0 and init_done rises 1024 cycles after the second reset release.
